mux_frame_serializer: RTL and testbench
=======================================

Name: mux_frame_serializer

Overview:
- Upstream feeder for the K-to-1 word multiplexer.
- Accepts a frame of up to K SIZE-bit words in one parallel load and latches them into an internal K-entry register bank.
- Drives an internal Mux_k_to_1 select counter to emit the words one per handshake, lowest index first, on a valid/ready stream.
- Exposes the running select value so downstream datapaths can share it.

Parameters:
K, 4, number of words per frame (number of mux inputs); must be at least 2.
SIZE, 16, width of each word in bits.
BIT, $clog2(K), select width; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  frame load request.
in_ready  output  1  block can accept a frame.
in_data  input  K*SIZE  frame words, flattened; word i occupies bits [i*SIZE +: SIZE].
in_len  input  BIT+1  number of valid words in frame, 0..K.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  downstream accepts word.
out_data  output  SIZE  current word, equal to bank[sel] via Mux_k_to_1.
out_last  output  1  current word is the final word of the frame.
sel  output  BIT  current mux select (word index).
frame_done  output  1  one-cycle pulse after the last word's handshake.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, sel=0, stored length=0, out_valid=0, out_last=0, frame_done=0, in_ready=1.
  - Bank contents are don't-care but cleared to 0.
  - Reset applies mid-frame too: any partially sent frame is abandoned, with no frame_done.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: in_ready=0, out_valid=1.
- IDLE with in_valid=1 (load handshake):
  - Capture all K words into the bank and store len=min(in_len,K); in_len>K clamps to K.
  - Set sel=0.
  - If the clamped len=0: the frame is discarded, state stays IDLE, no output, frame_done not asserted.
  - Otherwise go to SEND next cycle.
- SEND:
  - out_data=bank[sel] combinationally; out_last=(sel==len-1).
  - On out_valid&out_ready with out_last=0: sel increments by 1.
  - On out_valid&out_ready with out_last=1: go to IDLE, sel returns to 0, frame_done=1 for exactly the next cycle.
  - out_ready=0: sel, out_data and out_last hold stable, and out_valid stays 1 (no retraction).
- Latency:
  - First word is valid one cycle after the load handshake.
  - With out_ready held high, a len-N frame occupies N cycles in SEND.
  - in_ready returns the cycle after the last handshake, so one bubble separates frames.
- in_data changes while in SEND have no effect; the bank is written only on the load handshake.
- sel never exceeds len-1 and never wraps past K-1.
- frame_done is registered and coincides with in_ready reasserting.
- A new load is legal in that same cycle.

Test Plan:
- Full frame:
  - Stimulus: K=4, SIZE=16; reset; load words AAAA,BBBB,CCCC,DDDD with in_len=4; out_ready=1.
  - Required: out_data AAAA,BBBB,CCCC,DDDD on consecutive cycles; sel 0,1,2,3; out_last only with DDDD; frame_done pulses the next cycle; in_ready=1 that cycle.
- Backpressure:
  - Stimulus: same frame; hold out_ready=0 for 3 cycles while sel=1.
  - Required: out_data stays BBBB, sel stays 1, out_valid stays 1; sequence resumes with CCCC once out_ready=1.
- Short and zero length:
  - Stimulus: in_len=2.
  - Required: only AAAA,BBBB emitted; out_last with BBBB.
  - Stimulus: in_len=0.
  - Required: no out_valid, no frame_done, in_ready stays 1.
  - Stimulus: in_len=7 (exceeds K=4).
  - Required: treated as 4.
- Load isolation:
  - Stimulus: change in_data to 1111.. during SEND.
  - Required: outputs still AAAA..DDDD.
  - Stimulus: in_valid=1 during SEND.
  - Required: ignored.
- Mid-frame reset:
  - Stimulus: assert rst while sel=2.
  - Required: next cycle out_valid=0, sel=0, in_ready=1, frame_done=0; a fresh load then emits from word 0.
- Back-to-back frames:
  - Stimulus: second load presented in the frame_done cycle.
  - Required: it is accepted; its first word is valid one cycle later.

Source files
------------

// File: rtl/mux_frame_serializer.sv
// Frame serializer: latches up to K words per load and streams them
// out one per valid/ready handshake through a K-to-1 word select.
module mux_frame_serializer #(
    parameter  int K    = 4,
    parameter  int SIZE = 16,
    localparam int BIT  = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K*SIZE-1:0] in_data,
    input  logic [BIT:0]      in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SIZE-1:0]   out_data,
    output logic              out_last,
    output logic [BIT-1:0]    sel,
    output logic              frame_done
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [BIT:0] KLEN = (BIT+1)'(K);
    localparam logic [BIT:0] ONE  = (BIT+1)'(1);

    state_t          r_state;
    state_t          w_next_state;
    logic [SIZE-1:0] r_bank [K];
    logic [BIT-1:0]  r_sel;
    logic [BIT:0]    r_len;
    logic            r_done;

    logic [BIT:0]    w_len_clamp;
    logic            w_last;
    logic            w_load;
    logic            w_adv;
    logic            w_fin;

    assign w_len_clamp = (in_len > KLEN) ? KLEN : in_len;
    assign w_last      = (r_state == SEND) && ({1'b0, r_sel} == r_len - ONE);

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_fin        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    // A zero-length frame is swallowed without leaving IDLE
                    if (w_len_clamp != '0) w_next_state = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_fin        = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < K; i++) r_bank[i] <= '0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                for (int i = 0; i < K; i++) r_bank[i] <= in_data[i*SIZE +: SIZE];
                r_len <= w_len_clamp;
                r_sel <= '0;
            end else if (w_adv) begin
                r_sel <= r_sel + BIT'(1);
            end else if (w_fin) begin
                r_sel <= '0;
            end
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == SEND);
    assign out_last   = w_last;
    assign out_data   = r_bank[r_sel];
    assign sel        = r_sel;
    assign frame_done = r_done;

endmodule

// File: tb/tb_mux_frame_serializer.sv
// Bench for mux_frame_serializer: directed frames plus random traffic
// checked against a queue-based frame model.
module tb_mux_frame_serializer;

    localparam int K    = 4;
    localparam int SIZE = 16;
    localparam int BIT  = $clog2(K);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [K*SIZE-1:0] in_data;
    logic [BIT:0]      in_len;
    logic              out_valid;
    logic              out_ready;
    logic [SIZE-1:0]   out_data;
    logic              out_last;
    logic [BIT-1:0]    sel;
    logic              frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [SIZE-1:0] m_q[$];
    int              m_len  = 0;
    bit              m_done = 1'b0;

    localparam logic [K*SIZE-1:0] FRAME = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

    mux_frame_serializer #(.K(K), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        bit busy;
        busy = (m_q.size() != 0);
        check("in_ready",   32'(in_ready),   32'(!busy));
        check("out_valid",  32'(out_valid),  32'(busy));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("sel", 32'(sel), busy ? 32'(m_len - m_q.size()) : 32'd0);
        if (busy) begin
            check("out_data", 32'(out_data), 32'(m_q[0]));
            check("out_last", 32'(out_last), 32'(m_q.size() == 1));
        end else begin
            check("out_last_idle", 32'(out_last), 32'd0);
        end
    endtask

    task automatic model_update();
        int n;
        if (rst) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_q.size() == 0) begin
            m_done = 1'b0;
            if (in_valid) begin
                n = (int'(in_len) > K) ? K : int'(in_len);
                for (int i = 0; i < n; i++) m_q.push_back(in_data[i*SIZE +: SIZE]);
                m_len = n;
            end
        end else begin
            m_done = 1'b0;
            if (out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end
    endtask

    task automatic step();
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [K*SIZE-1:0] d, input int len);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = (BIT+1)'(len);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_sel",        32'(sel),        32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);

        // full frame
        load(FRAME, 4);
        check("full_w0", 32'(out_data), 32'hAAAA);
        repeat (4) step();
        check("full_done", 32'(frame_done), 32'd1);
        step();

        // backpressure at sel=1
        load(FRAME, 4);
        step();
        out_ready = 1'b0;
        repeat (3) begin
            step();
            check("bp_data",  32'(out_data),  32'hBBBB);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume", 32'(out_data), 32'hCCCC);
        repeat (3) step();

        // short, zero and over-long frames
        load(FRAME, 2);
        repeat (3) step();
        load(FRAME, 0);
        repeat (3) step();
        load(FRAME, 7);
        repeat (5) step();

        // load isolation: new data and in_valid during SEND are ignored
        load(FRAME, 4);
        in_data  = {K{16'h1111}};
        in_valid = 1'b1;
        in_len   = 3'd1;
        repeat (4) step();
        in_valid = 1'b0;
        step();

        // mid-frame reset at sel=2
        load(FRAME, 4);
        repeat (2) step();
        check("pre_rst_sel", 32'(sel), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid),  32'd0);
        check("mrst_sel",   32'(sel),        32'd0);
        check("mrst_ready", 32'(in_ready),   32'd1);
        check("mrst_done",  32'(frame_done), 32'd0);
        load(FRAME, 4);
        check("mrst_w0", 32'(out_data), 32'hAAAA);
        repeat (5) step();

        // back-to-back: load presented in the frame_done cycle
        load(FRAME, 2);
        repeat (2) step();
        check("b2b_done", 32'(frame_done), 32'd1);
        load({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 3);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_w0",    32'(out_data),  32'h1111);
        repeat (4) step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_len    = (BIT+1)'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < K; i++) in_data[i*SIZE +: SIZE] = SIZE'($urandom);
            step();
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
